// File: rtl/l1_tlb_refill_ctrl_pkg.sv
// Shared constants, FSM state type and helpers for the L1 TLB miss/refill controller.
package l1_tlb_pkg;

  localparam int L1TLB_ENTRIES = 8;
  localparam int L1TLB_IDX_W   = 3;

  typedef enum logic [1:0] {
    S_READY    = 2'd0,
    S_REQUEST  = 2'd1,
    S_WAIT     = 2'd2,
    S_WAIT_INV = 2'd3
  } l1tlb_state_e;

  // Scanning downward leaves the lowest invalid index as the result.
  function automatic logic [L1TLB_IDX_W-1:0] first_invalid(input logic [L1TLB_ENTRIES-1:0] v);
    logic [L1TLB_IDX_W-1:0] r;
    r = '0;
    for (int i = L1TLB_ENTRIES - 1; i >= 0; i--) begin
      if (!v[i]) r = L1TLB_IDX_W'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/l1_tlb_refill_ctrl_if.sv
// Request / L2 TLB / refill signal bundle of the L1 TLB refill controller.
interface l1_tlb_refill_ctrl_if #(
  parameter int VPN_W = 27
);
  import l1_tlb_pkg::*;

  logic                   io_req_valid;
  logic                   io_req_ready;
  logic [VPN_W-1:0]       io_req_bits_vpn;
  logic                   io_lookup_miss;
  logic                   io_hit_valid;
  logic [L1TLB_IDX_W-1:0] io_hit_idx;
  logic [L1TLB_ENTRIES-1:0] valid;
  logic                   io_ptw_invalidate;
  logic                   io_l2tlb_req_valid;
  logic                   io_l2tlb_req_ready;
  logic [VPN_W-1:0]       io_l2tlb_req_bits_vpn;
  logic                   io_l2tlb_resp_valid;
  logic                   io_refill_valid;
  logic [L1TLB_IDX_W-1:0] r_refill_waddr;
  logic [VPN_W-1:0]       r_refill_tag;
  logic                   io_miss_busy;

  modport master (
    output io_req_valid, io_req_bits_vpn, io_lookup_miss, io_hit_valid, io_hit_idx,
           valid, io_ptw_invalidate, io_l2tlb_req_ready, io_l2tlb_resp_valid,
    input  io_req_ready, io_l2tlb_req_valid, io_l2tlb_req_bits_vpn, io_refill_valid,
           r_refill_waddr, r_refill_tag, io_miss_busy
  );

  modport slave (
    input  io_req_valid, io_req_bits_vpn, io_lookup_miss, io_hit_valid, io_hit_idx,
           valid, io_ptw_invalidate, io_l2tlb_req_ready, io_l2tlb_resp_valid,
    output io_req_ready, io_l2tlb_req_valid, io_l2tlb_req_bits_vpn, io_refill_valid,
           r_refill_waddr, r_refill_tag, io_miss_busy
  );

endinterface

// File: rtl/l1_tlb_refill_ctrl_plru8.sv
// 8-leaf tree pseudo-LRU; root splits on idx[0], then idx[1], leaves on idx[2].
module l1_tlb_plru8
  import l1_tlb_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   touch_valid,
  input  logic [L1TLB_IDX_W-1:0] touch_idx,
  output logic [L1TLB_IDX_W-1:0] victim
);

  // Each node bit holds the index bit of the child the victim walk takes.
  logic [6:0] tree;
  logic       v0, v1, v2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tree <= '0;
    end else if (touch_valid) begin
      tree[0]                              <= ~touch_idx[0];
      tree[3'd1 + {2'b00, touch_idx[0]}]   <= ~touch_idx[1];
      tree[3'd3 + {1'b0, touch_idx[1:0]}]  <= ~touch_idx[2];
    end
  end

  assign v0     = tree[0];
  assign v1     = tree[3'd1 + {2'b00, v0}];
  assign v2     = tree[3'd3 + {1'b0, v1, v0}];
  assign victim = {v2, v1, v0};

endmodule

// File: rtl/l1_tlb_refill_ctrl.sv
// L1 TLB miss/refill controller: victim pick, single L2 TLB request, gated refill strobe.
// Define L1TLB_PLRU_EN for tree pseudo-LRU replacement; otherwise round-robin.
module l1_tlb_refill_ctrl
  import l1_tlb_pkg::*;
#(
  parameter int ENTRIES = 8,
  parameter int VPN_W   = 27
) (
  input logic clk,
  input logic reset,
  l1_tlb_refill_ctrl_if.slave bus
);

  l1tlb_state_e           state;
  logic                   req_ready;
  logic                   l2_req_valid;
  logic                   miss_busy;
  logic                   refill_valid;
  logic [L1TLB_IDX_W-1:0] refill_waddr;
  logic [VPN_W-1:0]       refill_tag;
  logic [L1TLB_IDX_W-1:0] repl_idx;
  logic [L1TLB_IDX_W-1:0] victim_idx;
  logic [ENTRIES-1:0]     entry_valid;
  logic                   miss_start;

  assign entry_valid  = bus.valid;
  assign victim_idx   = (&entry_valid) ? repl_idx : first_invalid(entry_valid);
  assign miss_start   = bus.io_req_valid & bus.io_lookup_miss & ~bus.io_ptw_invalidate;
  // The raw L2 strobe only counts while a live (non-flushed) miss is waiting.
  assign refill_valid = (state == S_WAIT) & bus.io_l2tlb_resp_valid & ~bus.io_ptw_invalidate;

`ifdef L1TLB_PLRU_EN
  logic                   touch_valid;
  logic [L1TLB_IDX_W-1:0] touch_idx;

  assign touch_valid = refill_valid | bus.io_hit_valid;
  assign touch_idx   = refill_valid ? refill_waddr : bus.io_hit_idx;

  l1_tlb_plru8 u_plru (
    .clk         (clk),
    .reset       (reset),
    .touch_valid (touch_valid),
    .touch_idx   (touch_idx),
    .victim      (repl_idx)
  );
`else
  logic [L1TLB_IDX_W-1:0] rr_ptr;
  logic                   unused_hit;

  assign unused_hit = ^{bus.io_hit_valid, bus.io_hit_idx};

  always_ff @(posedge clk or posedge reset) begin
    if (reset)             rr_ptr <= '0;
    else if (refill_valid) rr_ptr <= rr_ptr + 1'b1;
  end

  assign repl_idx = rr_ptr;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_READY;
      req_ready    <= 1'b1;
      l2_req_valid <= 1'b0;
      miss_busy    <= 1'b0;
      refill_waddr <= '0;
      refill_tag   <= '0;
    end else begin
      case (state)
        S_READY: begin
          if (miss_start) begin
            refill_tag   <= bus.io_req_bits_vpn;
            refill_waddr <= victim_idx;
            state        <= S_REQUEST;
            req_ready    <= 1'b0;
            l2_req_valid <= 1'b1;
            miss_busy    <= 1'b1;
          end
        end
        S_REQUEST: begin
          // A flush cancels the miss even if the L2 TLB is ready this cycle.
          if (bus.io_ptw_invalidate) begin
            state        <= S_READY;
            req_ready    <= 1'b1;
            l2_req_valid <= 1'b0;
            miss_busy    <= 1'b0;
          end else if (bus.io_l2tlb_req_ready) begin
            state        <= S_WAIT;
            l2_req_valid <= 1'b0;
          end
        end
        S_WAIT: begin
          if (bus.io_l2tlb_resp_valid) begin
            state     <= S_READY;
            req_ready <= 1'b1;
            miss_busy <= 1'b0;
          end else if (bus.io_ptw_invalidate) begin
            state <= S_WAIT_INV;
          end
        end
        S_WAIT_INV: begin
          if (bus.io_l2tlb_resp_valid) begin
            state     <= S_READY;
            req_ready <= 1'b1;
            miss_busy <= 1'b0;
          end
        end
        default: begin
          state        <= S_READY;
          req_ready    <= 1'b1;
          l2_req_valid <= 1'b0;
          miss_busy    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.io_req_ready          = req_ready;
  assign bus.io_l2tlb_req_valid    = l2_req_valid;
  assign bus.io_l2tlb_req_bits_vpn = refill_tag;
  assign bus.io_refill_valid       = refill_valid;
  assign bus.r_refill_waddr        = refill_waddr;
  assign bus.r_refill_tag          = refill_tag;
  assign bus.io_miss_busy          = miss_busy;

endmodule

// File: tb/tb_l1_tlb_refill_ctrl.sv
// Bench for l1_tlb_refill_ctrl: vector table, directed flush/reset sequences, random run vs. model.
module tb_l1_tlb_refill_ctrl;

  localparam int VW = 27;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  l1_tlb_refill_ctrl_if #(.VPN_W(VW)) bus ();

  l1_tlb_refill_ctrl #(.ENTRIES(8), .VPN_W(VW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic          req_valid;
    logic          miss;
    logic [VW-1:0] vpn;
    logic          hit_valid;
    logic [2:0]    hit_idx;
    logic [7:0]    valid;
    logic          inv;
    logic          l2_ready;
    logic          resp;
    logic          e_ready;
    logic          e_l2v;
    logic          e_rv;
    logic          e_busy;
    logic [2:0]    e_waddr;
    logic [VW-1:0] e_tag;
  } vec_t;

  vec_t tbl[7];

  // Behavioural model: phase 0 idle, 1 requesting, 2 waiting, 3 waiting (dropped).
  int          m_phase;
  int          m_waddr;
  int          m_tag;
  int          m_rr;
  int          m_now;
  int          ts[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string name, input logic e_ready, input logic e_l2v,
                         input logic e_rv, input logic e_busy, input logic [2:0] e_waddr,
                         input logic [VW-1:0] e_tag);
    chk({name, ".req_ready"}, 32'(bus.io_req_ready), 32'(e_ready));
    chk({name, ".l2_req_valid"}, 32'(bus.io_l2tlb_req_valid), 32'(e_l2v));
    chk({name, ".refill_valid"}, 32'(bus.io_refill_valid), 32'(e_rv));
    chk({name, ".miss_busy"}, 32'(bus.io_miss_busy), 32'(e_busy));
    chk({name, ".waddr"}, 32'(bus.r_refill_waddr), 32'(e_waddr));
    chk({name, ".tag"}, 32'(bus.r_refill_tag), 32'(e_tag));
    chk({name, ".l2_vpn"}, 32'(bus.io_l2tlb_req_bits_vpn), 32'(e_tag));
  endtask

  task automatic set_in(input logic rv, input logic miss, input logic [VW-1:0] vpn,
                        input logic hv, input logic [2:0] hidx, input logic [7:0] valid,
                        input logic inv, input logic l2r, input logic resp);
    bus.io_req_valid        = rv;
    bus.io_lookup_miss      = miss;
    bus.io_req_bits_vpn     = vpn;
    bus.io_hit_valid        = hv;
    bus.io_hit_idx          = hidx;
    bus.valid               = valid;
    bus.io_ptw_invalidate   = inv;
    bus.io_l2tlb_req_ready  = l2r;
    bus.io_l2tlb_resp_valid = resp;
  endtask

  task automatic idle(input logic [7:0] valid);
    set_in(1'b0, 1'b0, '0, 1'b0, 3'd0, valid, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle(8'h00);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic model_reset();
    m_phase = 0; m_waddr = 0; m_tag = 0; m_rr = 0; m_now = 0;
    for (int i = 0; i < 8; i++) ts[i] = 0;
  endtask

  // Most recent touch time among entries whose index matches val under mask.
  function automatic int group_last(input int mask, input int val);
    int r;
    r = 0;
    for (int i = 0; i < 8; i++)
      if (((i & mask) == val) && ts[i] > r) r = ts[i];
    return r;
  endfunction

  // At each split, the victim lies in the half not holding the most recent touch.
  function automatic int model_victim(input logic [7:0] valid);
    int v0, v1, v2;
    for (int i = 0; i < 8; i++)
      if (!valid[i]) return i;
`ifdef L1TLB_PLRU_EN
    v0 = (group_last(1, 1) < group_last(1, 0)) ? 1 : 0;
    v1 = (group_last(3, 2 + v0) < group_last(3, v0)) ? 1 : 0;
    v2 = (group_last(7, 4 + 2 * v1 + v0) < group_last(7, 2 * v1 + v0)) ? 1 : 0;
    return 4 * v2 + 2 * v1 + v0;
`else
    v0 = 0; v1 = 0; v2 = 0;
    return m_rr + v0 + v1 + v2;
`endif
  endfunction

  task automatic touch(input int idx);
    m_now++;
    ts[idx] = m_now;
  endtask

  initial begin
    logic          r_rv, r_miss, r_hv, r_inv, r_l2r, r_resp, e_rv;
    logic [2:0]    r_hidx;
    logic [7:0]    r_valid;
    logic [VW-1:0] r_vpn;
    int            vic;
    logic [2:0]    exp_w2;

    reset = 1'b1;
    idle(8'h00);
    #1;
    chk_all("reset", 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, '0);
    @(negedge clk);
    reset = 1'b0;

    // Miss on 8'h0F: first invalid is 4, response three cycles after the request.
    tbl[0] = '{1'b0, 1'b0, 27'h0,   1'b0, 3'd0, 8'h0F, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 27'h0};
    tbl[1] = '{1'b1, 1'b1, 27'h123, 1'b0, 3'd0, 8'h0F, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 27'h0};
    tbl[2] = '{1'b0, 1'b0, 27'h0,   1'b0, 3'd0, 8'h0F, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 3'd4, 27'h123};
    tbl[3] = '{1'b0, 1'b0, 27'h0,   1'b0, 3'd0, 8'h0F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd4, 27'h123};
    tbl[4] = '{1'b0, 1'b0, 27'h0,   1'b0, 3'd0, 8'h0F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd4, 27'h123};
    tbl[5] = '{1'b0, 1'b0, 27'h0,   1'b0, 3'd0, 8'h0F, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 3'd4, 27'h123};
    tbl[6] = '{1'b0, 1'b0, 27'h0,   1'b0, 3'd0, 8'h0F, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd4, 27'h123};

    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      set_in(tbl[i].req_valid, tbl[i].miss, tbl[i].vpn, tbl[i].hit_valid, tbl[i].hit_idx,
             tbl[i].valid, tbl[i].inv, tbl[i].l2_ready, tbl[i].resp);
      #1;
      chk_all($sformatf("vec%0d", i), tbl[i].e_ready, tbl[i].e_l2v, tbl[i].e_rv,
              tbl[i].e_busy, tbl[i].e_waddr, tbl[i].e_tag);
    end

    // All valid: victim from replacement state after hits on 0..6.
    do_reset();
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      set_in(1'b0, 1'b0, '0, 1'b1, 3'(i), 8'hFF, 1'b0, 1'b0, 1'b0);
    end
    @(negedge clk);
    set_in(1'b1, 1'b1, 27'h55, 1'b0, 3'd0, 8'hFF, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    idle(8'hFF);
    #1;
`ifdef L1TLB_PLRU_EN
    exp_w2 = 3'd7;
`else
    exp_w2 = 3'd0;
`endif
    chk_all("repl_victim", 1'b0, 1'b1, 1'b0, 1'b1, exp_w2, 27'h55);

    // Flush in S_REQUEST with L2 not ready: miss is abandoned.
    do_reset();
    @(negedge clk); set_in(1'b1, 1'b1, 27'h3A, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0);
    @(negedge clk); set_in(1'b0, 1'b0, '0, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 1'b0); #1;
    chk_all("inv_req.during", 1'b0, 1'b1, 1'b0, 1'b1, 3'd0, 27'h3A);
    @(negedge clk); idle(8'h00); #1;
    chk_all("inv_req.after", 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 27'h3A);
    @(negedge clk); set_in(1'b0, 1'b0, '0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b1); #1;
    chk_all("inv_req.stale_resp", 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 27'h3A);

    // Flush in S_WAIT, response two cycles later is swallowed.
    do_reset();
    @(negedge clk); set_in(1'b1, 1'b1, 27'h4B, 1'b0, 3'd0, 8'h03, 1'b0, 1'b0, 1'b0);
    @(negedge clk); set_in(1'b0, 1'b0, '0, 1'b0, 3'd0, 8'h03, 1'b0, 1'b1, 1'b0);
    @(negedge clk); set_in(1'b0, 1'b0, '0, 1'b0, 3'd0, 8'h03, 1'b1, 1'b0, 1'b0); #1;
    chk_all("inv_wait.flush", 1'b0, 1'b0, 1'b0, 1'b1, 3'd2, 27'h4B);
    @(negedge clk); idle(8'h03); #1;
    chk_all("inv_wait.held", 1'b0, 1'b0, 1'b0, 1'b1, 3'd2, 27'h4B);
    @(negedge clk); set_in(1'b0, 1'b0, '0, 1'b0, 3'd0, 8'h03, 1'b0, 1'b0, 1'b1); #1;
    chk_all("inv_wait.resp", 1'b0, 1'b0, 1'b0, 1'b1, 3'd2, 27'h4B);
    @(negedge clk); idle(8'h03); #1;
    chk_all("inv_wait.done", 1'b1, 1'b0, 1'b0, 1'b0, 3'd2, 27'h4B);

    // Response and flush together in S_WAIT.
    do_reset();
    @(negedge clk); set_in(1'b1, 1'b1, 27'h5C, 1'b0, 3'd0, 8'h01, 1'b0, 1'b0, 1'b0);
    @(negedge clk); set_in(1'b0, 1'b0, '0, 1'b0, 3'd0, 8'h01, 1'b0, 1'b1, 1'b0);
    @(negedge clk); set_in(1'b0, 1'b0, '0, 1'b0, 3'd0, 8'h01, 1'b1, 1'b0, 1'b1); #1;
    chk_all("resp_inv.same", 1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 27'h5C);
    @(negedge clk); idle(8'h01); #1;
    chk_all("resp_inv.after", 1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 27'h5C);

    // Reset while waiting: immediate reset values, later response ignored.
    do_reset();
    @(negedge clk); set_in(1'b1, 1'b1, 27'h7777, 1'b0, 3'd0, 8'h0F, 1'b0, 1'b0, 1'b0);
    @(negedge clk); set_in(1'b0, 1'b0, '0, 1'b0, 3'd0, 8'h0F, 1'b0, 1'b1, 1'b0);
    @(negedge clk); idle(8'h0F); #1;
    chk_all("rst_wait.before", 1'b0, 1'b0, 1'b0, 1'b1, 3'd4, 27'h7777);
    @(negedge clk); reset = 1'b1; #1;
    chk_all("rst_wait.async", 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 27'h0);
    @(negedge clk); reset = 1'b0;
    @(negedge clk); set_in(1'b0, 1'b0, '0, 1'b0, 3'd0, 8'h0F, 1'b0, 1'b0, 1'b1); #1;
    chk_all("rst_wait.stale_resp", 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 27'h0);

    // Randomized traffic against the reference model.
    do_reset();
    model_reset();
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      r_rv    = 1'($urandom_range(0, 1));
      r_miss  = 1'($urandom_range(0, 1));
      r_vpn   = VW'($urandom);
      r_hv    = 1'($urandom_range(0, 1));
      r_hidx  = 3'($urandom_range(0, 7));
      r_valid = ($urandom_range(0, 2) != 0) ? 8'hFF : 8'($urandom);
      r_inv   = ($urandom_range(0, 9) == 0);
      r_l2r   = 1'($urandom_range(0, 1));
      r_resp  = ($urandom_range(0, 2) == 0);
      set_in(r_rv, r_miss, r_vpn, r_hv, r_hidx, r_valid, r_inv, r_l2r, r_resp);
      #1;
      e_rv = (m_phase == 2) && r_resp && !r_inv;
      chk_all("rnd", m_phase == 0, m_phase == 1, e_rv, m_phase != 0, 3'(m_waddr), VW'(m_tag));
      vic = model_victim(r_valid);
      if (e_rv) begin
        touch(m_waddr);
        m_rr = (m_rr + 1) % 8;
      end else if (r_hv) begin
        touch(int'(r_hidx));
      end
      case (m_phase)
        0: if (r_rv && r_miss && !r_inv) begin
             m_phase = 1; m_tag = int'(r_vpn); m_waddr = vic;
           end
        1: if (r_inv) m_phase = 0; else if (r_l2r) m_phase = 2;
        2: if (r_resp) m_phase = 0; else if (r_inv) m_phase = 3;
        default: if (r_resp) m_phase = 0;
      endcase
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
